// File: rtl/seg_mux_ndigit.sv
// Time-multiplexed N-digit seven-segment driver: per-frame snapshot, blank/dwell scan slots.
// Optional leading-zero blanking is enabled by defining SEG_MUX_LZB_EN.

module seg_mux_lane (
  input  logic [3:0] nib,
  output logic [6:0] pat
);
  // Active-high pattern, bit 0 = segment a.
  always_comb begin
    case (nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      default: pat = 7'h71;
    endcase
  end
endmodule

module seg_mux_ndigit #(
  parameter int NUM_DIGITS     = 4,
  parameter int DWELL_CYCLES   = 25000,
  parameter int BLANK_CYCLES   = 500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [4*NUM_DIGITS-1:0]       hex_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  output logic [6:0]                    seg,
  output logic                          dp,
  output logic [NUM_DIGITS-1:0]         digit_en,
  output logic [$clog2(NUM_DIGITS)-1:0] cur_digit,
  output logic                          frame_start
);
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] DW_LD = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BL_LD = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;
  localparam logic [IW-1:0] LAST  = IW'(NUM_DIGITS - 1);
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic DIG_INV = (DIG_ACTIVE_LOW != 0);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t                        state, state_n;
  logic [IW-1:0]                 idx, idx_n;
  logic [CW-1:0]                 cnt, cnt_n;
  logic                          snap_ld;
  logic [NUM_DIGITS-1:0][3:0]    snap_hex, snap_hex_n;
  logic [NUM_DIGITS-1:0]         snap_dp, snap_dp_n;
  logic [NUM_DIGITS-1:0][6:0]    pat;
  logic [NUM_DIGITS-1:0]         oh_n;
  logic                          dark_n;

  // cnt holds remaining cycles minus one in the current interval.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    snap_ld = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      idx_n   = '0;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          snap_ld = 1'b1;
          idx_n   = '0;
          if (BLANK_CYCLES == 0) begin
            state_n = SHOW;
            cnt_n   = DW_LD;
          end else begin
            state_n = BLANK;
            cnt_n   = BL_LD;
          end
        end
        BLANK: begin
          if (cnt == '0) begin
            state_n = SHOW;
            cnt_n   = DW_LD;
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
        SHOW: begin
          if (cnt == '0) begin
            if (idx == LAST) begin
              idx_n   = '0;
              snap_ld = 1'b1;
            end else begin
              idx_n = idx + 1'b1;
            end
            if (BLANK_CYCLES == 0) begin
              state_n = SHOW;
              cnt_n   = DW_LD;
            end else begin
              state_n = BLANK;
              cnt_n   = BL_LD;
            end
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          idx_n   = '0;
          cnt_n   = '0;
        end
      endcase
    end
  end

  assign snap_hex_n = snap_ld ? hex_in : snap_hex;
  assign snap_dp_n  = snap_ld ? dp_in  : snap_dp;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lane
    seg_mux_lane u_lane (.nib(snap_hex_n[g]), .pat(pat[g]));
  end

`ifdef SEG_MUX_LZB_EN
  // lz[i]: digits i..NUM_DIGITS-1 of the snapshot are all zero.
  logic [NUM_DIGITS:1]   lz;
  logic [NUM_DIGITS-1:0] lzb;
  assign lz[NUM_DIGITS] = 1'b1;
  assign lzb[0]         = 1'b0;
  for (genvar g = 1; g < NUM_DIGITS; g++) begin : g_lz
    assign lz[g]  = lz[g+1] & (snap_hex_n[g] == 4'h0);
    assign lzb[g] = lz[g] & ~snap_dp_n[g];
  end
  assign dark_n = (state_n != SHOW) | lzb[idx_n];
`else
  assign dark_n = (state_n != SHOW);
`endif

  assign oh_n = NUM_DIGITS'(1) << idx_n;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      snap_hex    <= '0;
      snap_dp     <= '0;
      seg         <= {7{SEG_INV}};
      dp          <= SEG_INV;
      digit_en    <= {NUM_DIGITS{DIG_INV}};
      cur_digit   <= '0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      cnt         <= cnt_n;
      snap_hex    <= snap_hex_n;
      snap_dp     <= snap_dp_n;
      seg         <= dark_n ? {7{SEG_INV}} : (pat[idx_n] ^ {7{SEG_INV}});
      dp          <= dark_n ? SEG_INV : (snap_dp_n[idx_n] ^ SEG_INV);
      digit_en    <= dark_n ? {NUM_DIGITS{DIG_INV}} : (oh_n ^ {NUM_DIGITS{DIG_INV}});
      cur_digit   <= idx_n;
      frame_start <= snap_ld;
    end
  end
endmodule

// File: doc/seg_mux_ndigit.md
# seg_mux_ndigit

Parametrised, time-multiplexed N-digit seven-segment display driver. It snapshots a packed hex word once per frame, then scans the digits one at a time, each scan slot being a blanking interval followed by a dwell interval. The blanking interval suppresses ghosting between digit transitions. The block sits between the system-level value sources (switches, counters, sum logic) and the board's shared segment bus and per-digit power pins, and replaces hand-built dual-digit multiplexing.

## Interface
- NUM_DIGITS, 4, number of digits scanned (2..8); digit 0 is least significant and rightmost.
- DWELL_CYCLES, 25000, clk cycles each digit is lit per slot (≥1).
- BLANK_CYCLES, 500, clk cycles all digits are dark before each slot (≥0).
- SEG_ACTIVE_LOW, 1, 1 means seg and dp are driven low when lit.
- DIG_ACTIVE_LOW, 1, 1 means digit_en is driven low when the digit is powered.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- enable  in  1  scan enable; 0 forces the display dark
- hex_in  in  4*NUM_DIGITS  packed nibbles; digit i = hex_in[4i+3:4i]
- dp_in  in  NUM_DIGITS  per-digit decimal point request
- seg  out  7  segments; seg[0]=a … seg[6]=g
- dp  out  1  decimal point
- digit_en  out  NUM_DIGITS  one-hot-active digit power
- cur_digit  out  $clog2(NUM_DIGITS)  index of the slot in progress
- frame_start  out  1  one-cycle pulse when a new snapshot is taken

## Operation
- States:
  - IDLE: dark, counters cleared, idx=0.
  - BLANK: dark, counting BLANK_CYCLES.
  - SHOW: digit_en[idx] active, seg/dp from the snapshot, counting DWELL_CYCLES.
- Transitions:
  - IDLE→BLANK when enable=1. At the same edge, take the snapshot (hex_in, dp_in) and set frame_start.
  - BLANK→SHOW after BLANK_CYCLES cycles.
  - SHOW→BLANK after DWELL_CYCLES cycles, with idx ← idx+1.
  - When idx=NUM_DIGITS-1, idx wraps to 0, a new snapshot is taken and frame_start pulses on that same edge.
  - BLANK_CYCLES=0: BLANK is skipped; SHOW→SHOW with the same idx/snapshot rules.
  - enable=0 in any state → IDLE at the next edge. enable has priority over counter expiry.
- Decode: standard hex 0–F in active-high form (0=7'b0111111, 4=7'b1100110, 8=7'b1111111, F=7'b1110001). The pattern is inverted when SEG_ACTIVE_LOW=1.
- Dark means:
  - seg and dp at the unlit level.
  - every digit_en bit at the unpowered level.
- The snapshot is the only source of displayed data. Changes to hex_in/dp_in mid-frame are not visible until the next frame_start.
- Dwell/blank counter width is $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1). The counter never wraps; it is reloaded on every state change.

## Timing
- All outputs are registered (Moore). They reflect the current state with no combinational path from any input.
- Reset (reset=0 at an edge):
  - state=IDLE, idx=0, snapshot=0.
  - seg and dp unlit, digit_en all unpowered, cur_digit=0, frame_start=0.
- Reset mid-scan aborts immediately: outputs are dark on the cycle after the reset edge.
- Latency from enable sampled 1 until digit 0 is lit: BLANK_CYCLES+1 edges.
- Slot period = BLANK_CYCLES+DWELL_CYCLES.
- Frame period = NUM_DIGITS*(BLANK_CYCLES+DWELL_CYCLES).
- The frame_start pulse is exactly one cycle, once per frame, including the first frame after IDLE.
- Two digit_en bits are never active in the same cycle, including across the wrap.
- cur_digit holds idx through both BLANK and SHOW of a slot. It is 0 in IDLE.

## Configuration
- SEG_MUX_LZB_EN defined:
  - Leading-zero blanking, evaluated on the snapshot.
  - Digit i>0 stays dark during its SHOW slot if it and every more-significant digit are 0 and dp_in for it is 0.
  - Slot timing is unchanged; the digit is simply not powered.
  - Digit 0 is never blanked.
- SEG_MUX_LZB_EN undefined: every digit is displayed, including leading zeros.

## Test plan
Bench parameters: NUM_DIGITS=4, DWELL_CYCLES=8, BLANK_CYCLES=2, both polarities active-low.

1. Hold reset=0 for 3 cycles, enable=1 → seg=7'h7F, dp=1, digit_en=4'hF, frame_start=0, cur_digit=0.
2. Release reset, hex_in=16'h1234, enable=1:
   - frame_start pulses once.
   - 3 edges later, digit_en=4'b1110 and seg=7'b0011001 ("4") for 8 cycles.
   - Then 2 dark cycles.
   - Then digit_en=4'b1101 with "3". Continue through the digits.
   - The next frame_start occurs 40 cycles after the first.
3. Change hex_in to 16'hABCD while digit 2 is lit → display keeps showing 1234 until the next frame_start, then digit 0 shows "D".
4. Drop enable during SHOW of digit 1:
   - Next cycle is fully dark, cur_digit=0.
   - Re-enable → new frame_start, and the scan restarts at digit 0.
5. Across 3 full frames → digit_en never has more than one bit low, and each slot has exactly 2 all-dark cycles between lit digits.
6. hex_in=16'h0070, dp_in=0:
   - With SEG_MUX_LZB_EN: digits 3 and 2 stay dark in their slots; digit 1 shows "7", digit 0 shows "0".
   - Without the macro: all four digits are lit.
   - With dp_in=4'b1000 and the macro: digit 3 shows "0" with dp lit.
